// File: rtl/vae_frame_io.sv
// Host-side frame buffer and stream endpoint for the VAE: sends 786 words out, collects up to 784 result words back.
// Optional result-wait timeout is enabled by defining VAE_IO_TIMEOUT_EN.
module vae_frame_io #(
  parameter int PIXELS         = 784,
  parameter int EPS_WORDS      = 2,
  parameter int DATA_W         = 20,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_wr_en,
  input  logic [9:0]        host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic [9:0]        host_rd_addr,
  output logic [DATA_W-1:0] host_rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [9:0]        rx_count,
  output logic              err_overflow,
  output logic              err_short,
  output logic              err_timeout,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              tx_valid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_last,
  input  logic              rx_valid
);

  localparam int TX_WORDS = PIXELS + EPS_WORDS;

  // The wait counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {IDLE, PREAMBLE, SEND, WAIT_RES, RECEIVE, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] tx_mem [TX_WORDS];
  logic [DATA_W-1:0] rx_mem [PIXELS];
  logic [9:0]        tx_idx;
  logic              host_idle;
  logic              tx_we;
  logic              rx_we;
  logic [9:0]        rx_waddr;
  logic              timeout_hit;

  assign host_idle = (state == IDLE) || (state == DONE);
  assign tx_we     = host_wr_en && host_idle && (host_wr_addr < 10'(TX_WORDS));

  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[host_wr_addr] <= host_wr_data;
  end

  // Words beyond the result capacity are dropped rather than written.
  assign rx_we    = !reset && rx_valid &&
                    ((state == WAIT_RES) || ((state == RECEIVE) && (rx_count < 10'(PIXELS))));
  assign rx_waddr = (state == WAIT_RES) ? 10'd0 : rx_count;

  always_ff @(posedge clk) begin
    if (rx_we) rx_mem[rx_waddr] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      host_rd_data <= '0;
    end else if (host_rd_addr < 10'(PIXELS)) begin
      host_rd_data <= rx_mem[host_rd_addr];
    end else begin
      host_rd_data <= '0;
    end
  end

`ifdef VAE_IO_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign timeout_hit = (state == WAIT_RES) && !rx_valid && (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if ((state == WAIT_RES) && !rx_valid) to_cnt <= to_cnt + 16'd1;
      else                                  to_cnt <= '0;
      if (host_idle && start)  err_timeout <= 1'b0;
      else if (timeout_hit)    err_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tx_idx       <= '0;
      tx_data      <= '0;
      tx_last      <= 1'b0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      rx_count     <= '0;
      err_overflow <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= PREAMBLE;
            busy         <= 1'b1;
            done         <= 1'b0;
            rx_count     <= '0;
            err_overflow <= 1'b0;
            err_short    <= 1'b0;
            tx_idx       <= '0;
            tx_valid     <= 1'b1;
            tx_last      <= 1'b0;
            tx_data      <= '0;
          end
        end
        // tx_idx points at the word to present next; the RAM read lands straight in tx_data.
        PREAMBLE, SEND: begin
          if ((state == SEND) && (tx_idx == 10'(TX_WORDS))) begin
            state    <= WAIT_RES;
            tx_valid <= 1'b0;
            tx_last  <= 1'b0;
            tx_data  <= '0;
          end else begin
            state   <= SEND;
            tx_data <= tx_mem[tx_idx];
            tx_last <= (tx_idx == 10'(TX_WORDS - 1));
            tx_idx  <= tx_idx + 10'd1;
          end
        end
        WAIT_RES: begin
          if (rx_valid) begin
            rx_count <= 10'd1;
            if (rx_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RECEIVE;
            end
          end else if (timeout_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        RECEIVE: begin
          if (!rx_valid) begin
            err_short <= 1'b1;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            if (rx_count == 10'(PIXELS)) err_overflow <= 1'b1;
            else                         rx_count     <= rx_count + 10'd1;
            if (rx_last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vae_frame_io.sv
// Directed bench for vae_frame_io: frame transmit, normal/overflow/short/single-word receive, reset mid-send.
module tb_vae_frame_io;

  localparam int PIXELS   = 784;
  localparam int DATA_W   = 20;
  localparam int TX_WORDS = 786;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_wr_en;
  logic [9:0]        host_wr_addr;
  logic [DATA_W-1:0] host_wr_data;
  logic [9:0]        host_rd_addr;
  logic [DATA_W-1:0] host_rd_data;
  logic              start;
  logic              busy;
  logic              done;
  logic [9:0]        rx_count;
  logic              err_overflow;
  logic              err_short;
  logic              err_timeout;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              tx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_last;
  logic              rx_valid;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vae_frame_io #(
    .PIXELS(PIXELS), .EPS_WORDS(2), .DATA_W(DATA_W), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset(reset),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .start(start), .busy(busy), .done(done), .rx_count(rx_count),
    .err_overflow(err_overflow), .err_short(err_short), .err_timeout(err_timeout),
    .tx_data(tx_data), .tx_last(tx_last), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulses start and checks every transmitted cycle; stop_at >= 0 returns while word stop_at is on the bus.
  task automatic send_frame(input int stop_at, input bit noise);
    start = 1'b1;
    for (int k = 1; k <= TX_WORDS + 2; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (noise && k == 100) begin rx_valid = 1'b1; rx_data = 20'h55555; end
      if (noise && k == 111) begin rx_valid = 1'b0; rx_data = '0; end
      if (k <= TX_WORDS + 1) begin
        chk("tx_valid", 32'(tx_valid), 32'd1);
        chk("busy_tx", 32'(busy), 32'd1);
        chk("tx_data", 32'(tx_data), (k == 1) ? 32'd0 : 32'(k - 2));
        chk("tx_last", 32'(tx_last), 32'(k == TX_WORDS + 1));
      end else begin
        chk("tx_valid_end", 32'(tx_valid), 32'd0);
        chk("tx_last_end", 32'(tx_last), 32'd0);
        chk("tx_data_end", 32'(tx_data), 32'd0);
      end
      if (stop_at >= 0 && k == stop_at + 2) return;
    end
  endtask

  task automatic rx_burst(input int n, input int last_idx);
    for (int i = 0; i < n; i++) begin
      rx_valid = 1'b1;
      rx_data  = DATA_W'(32'hA0000 + i);
      rx_last  = (i == last_idx);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_data  = '0;
    @(negedge clk);
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] exp, input string tag);
    host_rd_addr = a;
    @(negedge clk);
    chk(tag, 32'(host_rd_data), exp);
  endtask

  initial begin
    reset = 1'b1; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_addr = '0; start = 1'b0; rx_data = '0; rx_last = 1'b0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_last", 32'(tx_last), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_err_overflow", 32'(err_overflow), 32'd0);
    chk("rst_err_short", 32'(err_short), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    chk("rst_rd_data", 32'(host_rd_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < TX_WORDS; i++) begin
      host_wr_en = 1'b1; host_wr_addr = 10'(i); host_wr_data = DATA_W'(i);
      @(negedge clk);
    end
    host_wr_en = 1'b0;

    // Normal frame, with stray rx_valid during SEND that must be ignored.
    send_frame(-1, 1'b1);
    repeat (3) @(negedge clk);
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_done", 32'(done), 32'd0);
    rx_burst(784, 783);
    chk("n_done", 32'(done), 32'd1);
    chk("n_busy", 32'(busy), 32'd0);
    chk("n_rx_count", 32'(rx_count), 32'd784);
    chk("n_err_overflow", 32'(err_overflow), 32'd0);
    chk("n_err_short", 32'(err_short), 32'd0);
    chk("n_err_timeout", 32'(err_timeout), 32'd0);
    rd(10'd5, 32'hA0005, "rd5");
    rd(10'd0, 32'hA0000, "rd0");
    rd(10'd783, 32'hA030F, "rd783");
    rd(10'd900, 32'd0, "rd_oob");

    // Overflow: 790 words, last on the final one.
    send_frame(-1, 1'b0);
    chk("o_rx_count_clr", 32'(rx_count), 32'd0);
    chk("o_done_clr", 32'(done), 32'd0);
    rx_burst(790, 789);
    chk("o_err_overflow", 32'(err_overflow), 32'd1);
    chk("o_rx_count", 32'(rx_count), 32'd784);
    chk("o_done", 32'(done), 32'd1);
    chk("o_err_short", 32'(err_short), 32'd0);
    rd(10'd783, 32'hA030F, "o_rd783");

    // Short result; host write while busy must not reach the TX buffer.
    send_frame(-1, 1'b0);
    host_wr_en = 1'b1; host_wr_addr = 10'd0; host_wr_data = 20'h12345;
    @(negedge clk);
    host_wr_en = 1'b0;
    rx_burst(100, -1);
    chk("s_err_short", 32'(err_short), 32'd1);
    chk("s_rx_count", 32'(rx_count), 32'd100);
    chk("s_done", 32'(done), 32'd1);
    chk("s_err_overflow", 32'(err_overflow), 32'd0);
    rd(10'd99, 32'hA0063, "s_rd99");

    // Single-word result.
    send_frame(-1, 1'b0);
    rx_burst(1, 0);
    chk("w1_rx_count", 32'(rx_count), 32'd1);
    chk("w1_done", 32'(done), 32'd1);
    chk("w1_err_short", 32'(err_short), 32'd0);

    // Reset while word 300 is on the bus, then a clean resend from word 0.
    send_frame(300, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    chk("r_tx_valid", 32'(tx_valid), 32'd0);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_tx_data", 32'(tx_data), 32'd0);
    chk("r_done", 32'(done), 32'd0);
    chk("r_rx_count", 32'(rx_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    send_frame(-1, 1'b0);
`ifdef VAE_IO_TIMEOUT_EN
    repeat (49) @(negedge clk);
    chk("t_err_timeout_early", 32'(err_timeout), 32'd0);
    chk("t_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("t_err_timeout", 32'(err_timeout), 32'd1);
    chk("t_done", 32'(done), 32'd1);
    chk("t_rx_count", 32'(rx_count), 32'd0);
    chk("t_busy", 32'(busy), 32'd0);
`else
    rx_burst(784, 783);
    chk("f_done", 32'(done), 32'd1);
    chk("f_rx_count", 32'(rx_count), 32'd784);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
